mem_access_ctrl: RTL

Memory-stage load/store controller for the single-issue MIPS datapath, placed directly upstream of the load-extension mux. It owns a word-wide synchronous data RAM with no byte enables and executes lb/lbu/lh/lhu/lw and sb/sh/sw requests. Sub-word stores are done as read-modify-write. Load responses carry the raw aligned word plus size, sign and address-low-bit fields in the encoding the extension mux consumes (size 2'b11 word, 2'b10 half, 2'b01 byte).

---
 rtl/mem_access_if.sv | 28 ++
 rtl/mem_access_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mem_access_if.sv
// Request/response bus between the memory stage and mem_access_ctrl.
// master = requester (MIPS datapath), slave = the controller.
interface mem_access_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_word;
  logic [1:0]  rsp_size;
  logic        rsp_sign;
  logic [1:0]  rsp_addr_lo;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_word, rsp_size, rsp_sign, rsp_addr_lo, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_word, rsp_size, rsp_sign, rsp_addr_lo, rsp_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store controller owning a word-wide data RAM; sub-word stores are read-modify-write.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_access_ctrl #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic         clk,
  input  logic         rst,
  mem_access_if.slave  bus
);

  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [2:0] {IDLE, RD, MRG, WR, RSP} state_t;

  state_t                  state, state_next;
  logic                    we_q, sign_q, err_q;
  logic [1:0]              size_q, addr_lo_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [31:0]             wdata_q, word_q;
  logic [31:0]             merged, wr_word;
  logic                    accept, req_err;
  logic [1:0]              req_lo;
  logic                    addr_hi_unused;

  logic [31:0] mem [2**DEPTH_LOG2];

  // Upper address bits alias onto the RAM by design.
  assign addr_hi_unused = ^bus.req_addr[31:DEPTH_LOG2+2];

  assign accept = bus.req_valid && (state == IDLE);

  always_comb begin
    req_err = (bus.req_size == 2'b00);
    req_lo  = bus.req_addr[1:0];
`ifdef MISALIGN_TRAP_EN
    if ((bus.req_size == SZ_HALF && bus.req_addr[0]) ||
        (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00))
      req_err = 1'b1;
`else
    if (bus.req_size == SZ_HALF) req_lo = {bus.req_addr[1], 1'b0};
    if (bus.req_size == SZ_WORD) req_lo = 2'b00;
`endif
  end

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) begin
        if (req_err)                                  state_next = RSP;
        else if (!bus.req_we || bus.req_size != SZ_WORD) state_next = RD;
        else                                          state_next = WR;
      end
      RD:  state_next = we_q ? MRG : RSP;
      MRG: state_next = RSP;
      WR:  state_next = RSP;
      RSP: if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    merged = word_q;
    if (size_q == SZ_BYTE)
      merged[{addr_lo_q, 3'b000} +: 8] = wdata_q[7:0];
    else if (addr_lo_q[1])
      merged[31:16] = wdata_q[15:0];
    else
      merged[15:0]  = wdata_q[15:0];
  end

  assign wr_word = (state == MRG) ? merged : wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q      <= 1'b0;
      sign_q    <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= 2'b00;
      addr_lo_q <= 2'b00;
      idx_q     <= '0;
      wdata_q   <= '0;
      word_q    <= '0;
    end else begin
      if (accept) begin
        we_q      <= bus.req_we;
        sign_q    <= bus.req_sign;
        err_q     <= req_err;
        size_q    <= bus.req_size;
        addr_lo_q <= req_lo;
        idx_q     <= bus.req_addr[DEPTH_LOG2+1:2];
        wdata_q   <= bus.req_wdata;
        word_q    <= '0;
      end
      case (state)
        RD:      word_q <= mem[idx_q];
        MRG:     word_q <= merged;
        WR:      word_q <= wdata_q;
        default: ;
      endcase
    end
  end

  // NOTE: the RAM array is deliberately not reset; only the write is gated by rst.
  always_ff @(posedge clk) begin
    if (!rst && (state == MRG || state == WR))
      mem[idx_q] <= wr_word;
  end

  assign bus.req_ready   = (state == IDLE) && !rst;
  assign bus.rsp_valid   = (state == RSP);
  assign bus.rsp_word    = word_q;
  assign bus.rsp_size    = size_q;
  assign bus.rsp_sign    = sign_q;
  assign bus.rsp_addr_lo = addr_lo_q;
  assign bus.rsp_err     = err_q;

endmodule
